// File: rtl/prog_freq_divider.sv
// Runtime-programmable clock divider / clock-enable generator with TOGGLE, PULSE and PWM modes.
// New settings are staged in a shadow register and take effect only at a period boundary.
module prog_freq_divider #(
    parameter int          WIDTH        = 16,
    parameter int unsigned DEFAULT_DIV  = 9,
    parameter int unsigned DEFAULT_DUTY = 5,
    parameter int unsigned DEFAULT_MODE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             divLoad,
    input  logic [WIDTH-1:0] divIn,
    input  logic [WIDTH-1:0] dutyIn,
    input  logic [1:0]       modeIn,
    output logic             slowClk,
    output logic             tick,
    output logic             pending,
    output logic [WIDTH-1:0] count
);

    localparam logic [1:0] MODE_TOGGLE = 2'd0;
    localparam logic [1:0] MODE_PULSE  = 2'd1;
    localparam logic [1:0] MODE_PWM    = 2'd2;

    // Mode encoding 3 is an alias of PULSE; fold it at capture so compares stay exact.
    function automatic logic [1:0] norm_mode(input logic [1:0] m);
        logic [1:0] r;
        if (m == 2'd3) begin
            r = MODE_PULSE;
        end else begin
            r = m;
        end
        return r;
    endfunction

    localparam logic [WIDTH-1:0] RST_DIV  = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] RST_DUTY = WIDTH'(DEFAULT_DUTY);
    localparam logic [1:0]       RST_MODE = norm_mode(2'(DEFAULT_MODE));

    logic [WIDTH-1:0] count_q, count_d;
    logic             slow_q, slow_d;
    logic             tick_q, tick_d;
    logic             pending_q, pending_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] duty_q, duty_d;
    logic [1:0]       mode_q, mode_d;
    logic [WIDTH-1:0] sh_div_q, sh_div_d;
    logic [WIDTH-1:0] sh_duty_q, sh_duty_d;
    logic [1:0]       sh_mode_q, sh_mode_d;
    logic             wrap_s;
    logic             apply_s;

    // Next-state logic: counter, shadow capture, apply at wrap and output waveform.
    always_comb begin
        wrap_s    = en && (count_q == div_q);
        apply_s   = wrap_s && pending_q;
        count_d   = count_q;
        slow_d    = slow_q;
        tick_d    = 1'b0;
        sh_div_d  = sh_div_q;
        sh_duty_d = sh_duty_q;
        sh_mode_d = sh_mode_q;
        div_d     = div_q;
        duty_d    = duty_q;
        mode_d    = mode_q;

        // A load on the apply edge stages the new value while the old shadow is applied.
        if (divLoad) begin
            sh_div_d  = divIn;
            sh_duty_d = dutyIn;
            sh_mode_d = norm_mode(modeIn);
            pending_d = 1'b1;
        end else if (apply_s) begin
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end

        if (apply_s) begin
            div_d  = sh_div_q;
            duty_d = sh_duty_q;
            mode_d = sh_mode_q;
        end else begin
            div_d  = div_q;
            duty_d = duty_q;
            mode_d = mode_q;
        end

        if (en) begin
            tick_d = wrap_s;
            if (wrap_s) begin
                count_d = {WIDTH{1'b0}};
            end else begin
                count_d = count_q + WIDTH'(1'b1);
            end

            // On a mode change the output restarts at the new mode's count-0 level.
            if (apply_s && (sh_mode_q != mode_q)) begin
                slow_d = (sh_mode_q == MODE_PWM) && (sh_duty_q != {WIDTH{1'b0}});
            end else begin
                case (mode_d)
                    MODE_TOGGLE: slow_d = wrap_s ? ~slow_q : slow_q;
                    MODE_PWM:    slow_d = (count_d < duty_d);
                    MODE_PULSE:  slow_d = 1'b0;
                    default:     slow_d = 1'b0;
                endcase
            end
        end else begin
            tick_d  = 1'b0;
            count_d = count_q;
            slow_d  = slow_q;
        end
    end

    // State registers with asynchronous active-low reset to the parameter defaults.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q   <= {WIDTH{1'b0}};
            slow_q    <= 1'b0;
            tick_q    <= 1'b0;
            pending_q <= 1'b0;
            div_q     <= RST_DIV;
            duty_q    <= RST_DUTY;
            mode_q    <= RST_MODE;
            sh_div_q  <= RST_DIV;
            sh_duty_q <= RST_DUTY;
            sh_mode_q <= RST_MODE;
        end else begin
            count_q   <= count_d;
            slow_q    <= slow_d;
            tick_q    <= tick_d;
            pending_q <= pending_d;
            div_q     <= div_d;
            duty_q    <= duty_d;
            mode_q    <= mode_d;
            sh_div_q  <= sh_div_d;
            sh_duty_q <= sh_duty_d;
            sh_mode_q <= sh_mode_d;
        end
    end

    assign slowClk = slow_q;
    assign tick    = tick_q;
    assign pending = pending_q;
    assign count   = count_q;

endmodule

// File: tb/tb_prog_freq_divider.sv
// Directed bench for prog_freq_divider: defaults, reprogramming, PWM duty limits,
// P=0 and enable gating, last-write-wins shadow, and reset while a load is pending.
module tb_prog_freq_divider;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst;
    logic             en;
    logic             divLoad;
    logic [WIDTH-1:0] divIn;
    logic [WIDTH-1:0] dutyIn;
    logic [1:0]       modeIn;
    logic             slowClk;
    logic             tick;
    logic             pending;
    logic [WIDTH-1:0] count;

    int n_checks;
    int n_fail;

    prog_freq_divider #(
        .WIDTH(WIDTH),
        .DEFAULT_DIV(9),
        .DEFAULT_DUTY(5),
        .DEFAULT_MODE(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .divLoad(divLoad),
        .divIn(divIn),
        .dutyIn(dutyIn),
        .modeIn(modeIn),
        .slowClk(slowClk),
        .tick(tick),
        .pending(pending),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int p, input int d, input int m);
        divLoad = 1'b1;
        divIn   = WIDTH'(p);
        dutyIn  = WIDTH'(d);
        modeIn  = 2'(m);
        step();
        divLoad = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        en       = 1'b0;
        divLoad  = 1'b0;
        divIn    = '0;
        dutyIn   = '0;
        modeIn   = 2'd0;

        // 1: reset defaults, then TOGGLE with P=9
        step();
        check_val("rst_count", 32'(count), 32'd0);
        check_val("rst_slow", 32'(slowClk), 32'd0);
        check_val("rst_tick", 32'(tick), 32'd0);
        check_val("rst_pend", 32'(pending), 32'd0);
        rst = 1'b1;
        en  = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            step();
            check_val("t1_count", 32'(count), 32'(k % 10));
            check_val("t1_tick", 32'(tick), 32'((k % 10) == 0));
            check_val("t1_slow", 32'(slowClk), 32'((k / 10) % 2));
        end

        // 2: load P=3 with mode 3 (PULSE alias) at count 2
        step();
        step();
        check_val("t2_pre_count", 32'(count), 32'd2);
        load(3, 5, 3);
        check_val("t2_pend_set", 32'(pending), 32'd1);
        check_val("t2_count3", 32'(count), 32'd3);
        for (int k = 0; k < 6; k++) step();
        check_val("t2_pend_hold", 32'(pending), 32'd1);
        check_val("t2_count9", 32'(count), 32'd9);
        step();
        check_val("t2_apply_pend", 32'(pending), 32'd0);
        check_val("t2_apply_count", 32'(count), 32'd0);
        check_val("t2_apply_tick", 32'(tick), 32'd1);
        check_val("t2_apply_slow", 32'(slowClk), 32'd0);
        for (int j = 1; j <= 12; j++) begin
            step();
            check_val("t2_count", 32'(count), 32'(j % 4));
            check_val("t2_tick", 32'(tick), 32'((j % 4) == 0));
            check_val("t2_slow", 32'(slowClk), 32'd0);
        end

        // 3: PWM P=7, D=3 then D=0 then D=8
        load(7, 3, 2);
        step();
        step();
        check_val("t3_pre_count", 32'(count), 32'd3);
        step();
        check_val("t3_apply_count", 32'(count), 32'd0);
        check_val("t3_apply_slow", 32'(slowClk), 32'd1);
        check_val("t3_apply_tick", 32'(tick), 32'd1);
        for (int m = 1; m <= 16; m++) begin
            step();
            check_val("t3_d3_count", 32'(count), 32'(m % 8));
            check_val("t3_d3_slow", 32'(slowClk), 32'((m % 8) < 3));
        end
        load(7, 0, 2);
        check_val("t3_d3_tail", 32'(slowClk), 32'd1);
        for (int k = 0; k < 6; k++) step();
        step();
        check_val("t3_d0_apply", 32'(slowClk), 32'd0);
        for (int n = 1; n <= 8; n++) begin
            step();
            check_val("t3_d0_count", 32'(count), 32'(n % 8));
            check_val("t3_d0_slow", 32'(slowClk), 32'd0);
        end
        load(7, 8, 2);
        check_val("t3_d0_tail", 32'(slowClk), 32'd0);
        for (int k = 0; k < 6; k++) step();
        step();
        check_val("t3_d8_apply", 32'(slowClk), 32'd1);
        for (int n = 1; n <= 8; n++) begin
            step();
            check_val("t3_d8_count", 32'(count), 32'(n % 8));
            check_val("t3_d8_slow", 32'(slowClk), 32'd1);
        end

        // 4: P=0 TOGGLE, then freeze with en=0
        load(0, 5, 0);
        for (int k = 0; k < 6; k++) step();
        check_val("t4_pre_count", 32'(count), 32'd7);
        step();
        check_val("t4_apply_count", 32'(count), 32'd0);
        check_val("t4_apply_slow", 32'(slowClk), 32'd0);
        for (int k = 1; k <= 5; k++) begin
            step();
            check_val("t4_slow", 32'(slowClk), 32'(k % 2));
            check_val("t4_tick", 32'(tick), 32'd1);
            check_val("t4_count", 32'(count), 32'd0);
        end
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check_val("t4_hold_slow", 32'(slowClk), 32'd1);
            check_val("t4_hold_tick", 32'(tick), 32'd0);
            check_val("t4_hold_count", 32'(count), 32'd0);
        end
        en = 1'b1;
        step();
        check_val("t4_resume_slow", 32'(slowClk), 32'd0);
        check_val("t4_resume_tick", 32'(tick), 32'd1);

        // 5: last write wins, and a load coincident with the wrap edge
        load(9, 5, 0);
        check_val("t5_pend0", 32'(pending), 32'd1);
        step();
        check_val("t5_apply9_pend", 32'(pending), 32'd0);
        check_val("t5_apply9_count", 32'(count), 32'd0);
        step();
        load(5, 5, 0);
        load(6, 5, 0);
        load(2, 5, 0);
        check_val("t5_multi_pend", 32'(pending), 32'd1);
        check_val("t5_multi_count", 32'(count), 32'd4);
        for (int k = 0; k < 5; k++) step();
        check_val("t5_count9", 32'(count), 32'd9);
        step();
        check_val("t5_wrap_count", 32'(count), 32'd0);
        check_val("t5_wrap_pend", 32'(pending), 32'd0);
        step();
        step();
        check_val("t5_p2_count2", 32'(count), 32'd2);
        step();
        check_val("t5_p2_wrap", 32'(count), 32'd0);
        check_val("t5_p2_tick", 32'(tick), 32'd1);
        load(3, 5, 0);
        step();
        check_val("t5_pre_coinc", 32'(count), 32'd2);
        load(4, 5, 0);
        check_val("t5_coinc_count", 32'(count), 32'd0);
        check_val("t5_coinc_pend", 32'(pending), 32'd1);
        check_val("t5_coinc_tick", 32'(tick), 32'd1);
        for (int k = 0; k < 3; k++) step();
        check_val("t5_p3_count3", 32'(count), 32'd3);
        step();
        check_val("t5_p3_wrap", 32'(count), 32'd0);
        check_val("t5_p4_pend", 32'(pending), 32'd0);
        for (int k = 0; k < 4; k++) step();
        check_val("t5_p4_count4", 32'(count), 32'd4);
        step();
        check_val("t5_p4_wrap", 32'(count), 32'd0);

        // 6: reset mid-period with a load pending
        load(7, 5, 0);
        step();
        check_val("t6_pre_pend", 32'(pending), 32'd1);
        rst = 1'b0;
        #2;
        check_val("t6_rst_count", 32'(count), 32'd0);
        check_val("t6_rst_slow", 32'(slowClk), 32'd0);
        check_val("t6_rst_tick", 32'(tick), 32'd0);
        check_val("t6_rst_pend", 32'(pending), 32'd0);
        step();
        rst = 1'b1;
        check_val("t6_held_count", 32'(count), 32'd0);
        for (int k = 1; k <= 10; k++) begin
            step();
            check_val("t6_count", 32'(count), 32'(k % 10));
            check_val("t6_tick", 32'(tick), 32'(k == 10));
            check_val("t6_slow", 32'(slowClk), 32'(k == 10));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
